// File: rtl/cnt_arb_pkg.sv
// Shared definitions for the counter arbiter: FSM encodings, default widths
// and the round-robin pointer advance helper.
package cnt_arb_pkg;

  localparam int NREQ_DEF   = 4;
  localparam int DWIDTH_DEF = 7;

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_START = 2'b01;
  localparam logic [1:0] S_WAIT  = 2'b10;
  localparam logic [1:0] S_DONE  = 2'b11;

  // Index of the requester that gets first look after 'idx' was served.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1) % n;
  endfunction

endpackage

// File: rtl/cnt_rr_pick.sv
// Combinational round-robin search: first set request bit at or above ptr_i,
// wrapping past NREQ-1 back to 0.
module cnt_rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [IW-1:0]   win_o,
  output logic            vld_o
);

  // Scan offsets from farthest to nearest so the nearest set bit wins.
  always_comb begin
    int j;
    j     = 0;
    win_o = '0;
    vld_o = 1'b0;
    for (int off = NREQ - 1; off >= 0; off--) begin
      j = (int'(ptr_i) + off) % NREQ;
      if (req_i[j]) begin
        win_o = IW'(j);
        vld_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/counter_arbiter.sv
// Round-robin arbiter sharing one counter controller among NREQ requesters.
// Optional build macro: CNT_ARB_ZERO_SKIP_EN -- a winner posting a zero count
// skips the controller handshake and completes in a single S_DONE cycle.
module counter_arbiter
  import cnt_arb_pkg::*;
#(
  parameter int NREQ   = NREQ_DEF,
  parameter int DWIDTH = DWIDTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_i,
  input  logic [NREQ*DWIDTH-1:0] cnt_val_i,
  output logic [NREQ-1:0]        gnt_o,
  output logic [NREQ-1:0]        done_o,
  output logic                   busy_o,
  output logic                   ctrl_start_o,
  output logic [DWIDTH-1:0]      ctrl_cnt_val_o,
  input  logic                   ctrl_done_i
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [1:0]        state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [DWIDTH-1:0] val_q, val_d;

  logic [IW-1:0]     win;
  logic              win_vld;
  logic [DWIDTH-1:0] win_val;
  logic              win_zero;
  logic [NREQ-1:0]   own_oh;

  cnt_rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req_i (req_i),
    .ptr_i (ptr_q),
    .win_o (win),
    .vld_o (win_vld)
  );

  assign win_val = cnt_val_i[int'(win)*DWIDTH +: DWIDTH];

`ifdef CNT_ARB_ZERO_SKIP_EN
  assign win_zero = (win_val == '0);
`else
  // Zero is forwarded like any other value; downstream wrap decides timing.
  assign win_zero = 1'b0;
`endif

  // Next-state and datapath capture; idx/val only load when leaving S_IDLE
  // so the controller sees a stable value for the whole transaction.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    val_d   = val_q;
    ptr_d   = ptr_q;
    case (state_q)
      S_IDLE: begin
        if (win_vld) begin
          idx_d   = win;
          val_d   = win_val;
          state_d = win_zero ? S_DONE : S_START;
        end
      end
      S_START: state_d = S_WAIT;
      S_WAIT:  if (ctrl_done_i) state_d = S_DONE;
      S_DONE: begin
        ptr_d   = IW'(rr_next(int'(idx_q), NREQ));
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset clears everything, including a live transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      ptr_q   <= '0;
      val_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      val_q   <= val_d;
    end
  end

  // Outputs decode registered state only: no path from req_i/ctrl_done_i.
  assign own_oh         = NREQ'(1) << idx_q;
  assign gnt_o          = (state_q != S_IDLE) ? own_oh : '0;
  assign done_o         = (state_q == S_DONE) ? own_oh : '0;
  assign busy_o         = (state_q != S_IDLE);
  assign ctrl_start_o   = (state_q == S_START);
  assign ctrl_cnt_val_o = val_q;

endmodule

// File: tb/tb_counter_arbiter.sv
// Directed bench for counter_arbiter with a transaction-level reference model
// and a simple downstream controller responder.
`timescale 1ns/1ps
module tb_counter_arbiter;
  localparam int N  = 4;
  localparam int DW = 7;
`ifdef CNT_ARB_ZERO_SKIP_EN
  localparam bit ZS = 1'b1;
`else
  localparam bit ZS = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_i = '0;
  logic [N*DW-1:0] cnt_val_i;
  logic [N-1:0]    gnt_o, done_o;
  logic            busy_o, ctrl_start_o, ctrl_done_i;
  logic [DW-1:0]   ctrl_cnt_val_o;

  logic [DW-1:0]   vals [N];
  logic            resp_done = 1'b0, man_done = 1'b0;
  int              lat = 1, rcnt = 0;
  int              n_cmp = 0, n_err = 0, cyc = 0, n_done = 0, last_done_cyc = 0;
  int              st_own[$], st_val[$], st_cyc[$];

  always #5 clk = ~clk;

  counter_arbiter #(.NREQ(N), .DWIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req_i), .cnt_val_i(cnt_val_i),
    .gnt_o(gnt_o), .done_o(done_o), .busy_o(busy_o),
    .ctrl_start_o(ctrl_start_o), .ctrl_cnt_val_o(ctrl_cnt_val_o),
    .ctrl_done_i(ctrl_done_i)
  );

  assign ctrl_done_i = resp_done | man_done;

  always_comb begin
    cnt_val_i = '0;
    for (int k = 0; k < N; k++) cnt_val_i[k*DW +: DW] = vals[k];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int first_from(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  function automatic int oh2idx(input logic [N-1:0] v);
    for (int k = 0; k < N; k++) if (v[k]) return k;
    return -1;
  endfunction

  // Reference model: who owns the controller, whether its start cycle has
  // passed, whether completion is being reported, and whose turn is next.
  int            m_owner = -1, m_age = 0, m_ptr = 0;
  bit            m_fin = 1'b0;
  logic [DW-1:0] m_val = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner <= -1; m_age <= 0; m_fin <= 1'b0; m_ptr <= 0; m_val <= '0;
    end else if (m_owner < 0) begin
      if (req_i != '0) begin
        m_owner <= first_from(req_i, m_ptr);
        m_val   <= vals[first_from(req_i, m_ptr)];
        m_age   <= 0;
        m_fin   <= ZS && (vals[first_from(req_i, m_ptr)] == '0);
      end
    end else if (m_fin) begin
      m_ptr   <= (m_owner + 1) % N;
      m_owner <= -1;
      m_fin   <= 1'b0;
    end else if (m_age == 0) begin
      m_age <= 1;
    end else if (ctrl_done_i) begin
      m_fin <= 1'b1;
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Per-cycle compare of every output against the model.
  always @(negedge clk) begin
    logic [N-1:0] eg;
    eg = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
    chk("gnt",    32'(gnt_o),          32'(eg));
    chk("done",   32'(done_o),         32'(m_fin ? eg : '0));
    chk("busy",   32'(busy_o),         32'(m_owner >= 0));
    chk("start",  32'(ctrl_start_o),   32'(m_owner >= 0 && m_age == 0 && !m_fin));
    chk("cntval", 32'(ctrl_cnt_val_o), 32'(m_val));
    chk("onehot", 32'($onehot0(gnt_o)), 32'd1);
  end

  // Event log used by the hand-computed checks.
  always @(negedge clk) begin
    if (ctrl_start_o) begin
      st_own.push_back(oh2idx(gnt_o));
      st_val.push_back(int'(ctrl_cnt_val_o));
      st_cyc.push_back(cyc);
    end
    if (done_o != '0) begin
      n_done <= n_done + 1;
      last_done_cyc <= cyc;
    end
  end

  // Downstream controller: done pulse 'lat' cycles after the start cycle.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (!rst_n) rcnt = 0;
      else if (ctrl_start_o) rcnt = lat + 1;
      else if (rcnt > 0) rcnt--;
      resp_done = rst_n && (rcnt == 1);
    end
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_done(input string nm, input int max);
    int n;
    n = 0;
    tick();
    while (done_o == '0 && n < max) begin tick(); n++; end
    chk({nm, " done seen"}, 32'(done_o != '0), 32'd1);
  endtask

  task automatic chk_start(input string nm, input int i, input int own, input int v);
    chk({nm, " logged"}, 32'(st_own.size() > i), 32'd1);
    if (st_own.size() > i) begin
      chk({nm, " owner"}, 32'(st_own[i]), 32'(own));
      chk({nm, " value"}, 32'(st_val[i]), 32'(v));
    end
  endtask

  initial begin
    int c0, b, d0;
    int exp_own[5] = '{0, 1, 2, 3, 0};
    int exp_val[5] = '{1, 2, 3, 4, 1};
    for (int k = 0; k < N; k++) vals[k] = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    tick();
    chk("reset gnt", 32'(gnt_o), 32'd0);
    chk("reset busy", 32'(busy_o), 32'd0);
    chk("reset cntval", 32'(ctrl_cnt_val_o), 32'd0);
    tick();
    rst_n = 1'b1;

    // Single requester 2, value 5, controller done 5 cycles after start.
    lat = 5; vals[2] = 5; req_i = 4'b0100;
    c0 = cyc; b = st_own.size(); d0 = n_done;
    tick();
    chk("t1 gnt t+1", 32'(gnt_o), 32'b0100);
    chk("t1 start t+1", 32'(ctrl_start_o), 32'd1);
    req_i = '0;
    tick();
    chk("t1 start drops t+2", 32'(ctrl_start_o), 32'd0);
    wait_done("t1", 20);
    chk("t1 done vec", 32'(done_o), 32'b0100);
    tick();
    chk("t1 busy after", 32'(busy_o), 32'd0);
    chk("t1 single done", 32'(n_done - d0), 32'd1);
    chk("t1 start count", 32'(st_own.size() - b), 32'd1);
    chk_start("t1", b, 2, 5);
    if (st_cyc.size() > b) begin
      chk("t1 start cycle", 32'(st_cyc[b] - c0), 32'd1);
      chk("t1 done cycle", 32'(last_done_cyc - st_cyc[b]), 32'd6);
    end

    // All four requesting continuously from ptr 0.
    do_reset();
    lat = 2;
    for (int k = 0; k < N; k++) vals[k] = DW'(k + 1);
    b = st_own.size();
    req_i = 4'b1111;
    for (int i = 0; i < 5; i++) wait_done("t2", 20);
    req_i = '0;
    tick(); tick();
    chk("t2 start count", 32'(st_own.size() - b), 32'd5);
    for (int i = 0; i < 5; i++) chk_start("t2", b + i, exp_own[i], exp_val[i]);

    // Serve 1 alone (ptr -> 2), then 0 and 1 together: 0 first.
    vals[1] = 6; req_i = 4'b0010;
    wait_done("t3a", 20);
    req_i = '0;
    tick();
    b = st_own.size();
    vals[0] = 9; vals[1] = 10; req_i = 4'b0011;
    wait_done("t3b", 20);
    wait_done("t3c", 20);
    req_i = '0;
    tick();
    chk_start("t3 first", b, 0, 9);
    chk_start("t3 second", b + 1, 1, 10);

    // Reset while waiting on the controller, with requester 3 pending.
    lat = 20; vals[3] = 7; req_i = 4'b1000;
    tick(); tick(); tick();
    chk("t4 busy before", 32'(busy_o), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t4 gnt in reset", 32'(gnt_o), 32'd0);
    chk("t4 busy in reset", 32'(busy_o), 32'd0);
    chk("t4 cntval in reset", 32'(ctrl_cnt_val_o), 32'd0);
    chk("t4 start in reset", 32'(ctrl_start_o), 32'd0);
    tick(); tick();
    lat = 3; b = st_own.size(); c0 = cyc;
    rst_n = 1'b1;
    wait_done("t4", 20);
    req_i = '0;
    tick();
    chk_start("t4 regrant", b, 3, 7);
    if (st_cyc.size() > b) chk("t4 regrant cycle", 32'(st_cyc[b] - c0), 32'd1);

    // Spurious controller done in S_IDLE and S_START; request withdrawn in S_WAIT.
    man_done = 1'b1;
    tick();
    man_done = 1'b0;
    tick();
    chk("t5 idle ignores done", 32'(busy_o), 32'd0);
    lat = 4; vals[0] = 3; req_i = 4'b0001;
    tick();
    chk("t5 start", 32'(ctrl_start_o), 32'd1);
    man_done = 1'b1;
    tick();
    man_done = 1'b0;
    chk("t5 still waiting", 32'(busy_o && !done_o[0]), 32'd1);
    req_i = '0;
    d0 = n_done;
    wait_done("t5", 20);
    chk("t5 done vec", 32'(done_o), 32'b0001);
    tick();
    chk("t5 single done", 32'(n_done - d0), 32'd1);

    // Zero count on requester 1.
    lat = 2; vals[1] = '0; b = st_own.size();
    req_i = 4'b0010;
    tick();
`ifdef CNT_ARB_ZERO_SKIP_EN
    chk("t6 skip done t+1", 32'(done_o), 32'b0010);
    chk("t6 skip gnt t+1", 32'(gnt_o), 32'b0010);
    chk("t6 skip no start", 32'(ctrl_start_o), 32'd0);
    req_i = '0;
    tick();
    chk("t6 skip idle", 32'(busy_o), 32'd0);
    chk("t6 skip no start logged", 32'(st_own.size() - b), 32'd0);
`else
    chk("t6 zero start", 32'(ctrl_start_o), 32'd1);
    chk("t6 zero cntval", 32'(ctrl_cnt_val_o), 32'd0);
    req_i = '0;
    wait_done("t6", 20);
    chk("t6 done vec", 32'(done_o), 32'b0010);
    tick();
`endif

    tick(); tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
